// File: rtl/seq_multiplier_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encodings and default width.
package seq_multiplier_ctrl_pkg;
   localparam int MUL_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/seq_multiplier_ctrl_cla_adder_w.sv
// WIDTH-bit adder built as a ripple chain of 4-bit carry-lookahead slices.
module cla4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [3:0] g, p;
   logic [4:0] c;

   assign g    = a & b;
   assign p    = a ^ b;
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);
   assign sum  = p ^ c[3:0];
   assign cout = c[4];
endmodule

module cla_adder_w #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int NSL = WIDTH / 4;

   logic [NSL:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < NSL; i++) begin : g_slice
      cla4_slice u_slice (
         .a    (a[4*i +: 4]),
         .b    (b[4*i +: 4]),
         .cin  (c[i]),
         .sum  (sum[4*i +: 4]),
         .cout (c[i+1])
      );
   end

   assign cout = c[NSL];
endmodule

// File: rtl/seq_multiplier_ctrl.sv
// Unsigned WIDTH x WIDTH shift-add multiplier: one add-then-shift iteration per cycle.
module seq_multiplier_ctrl
   import seq_multiplier_ctrl_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH);

   state_t             state;
   logic [WIDTH-1:0]   m;
   logic [2*WIDTH-1:0] p;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   addend, sum;
   logic               cout;
   logic [2*WIDTH-1:0] p_nxt;

   assign addend = p[0] ? m : '0;

   cla_adder_w #(.WIDTH(WIDTH)) u_add (
      .a    (p[2*WIDTH-1:WIDTH]),
      .b    (addend),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   // Carry-out lands in the MSB, so the upper half never overflows.
   assign p_nxt = {cout, sum, p[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         m       <= '0;
         p       <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  m     <= a;
                  p     <= {{WIDTH{1'b0}}, b};
                  cnt   <= CW'(WIDTH - 1);
                  busy  <= 1'b1;
                  state <= ST_CALC;
               end
            end
            ST_CALC: begin
               p <= p_nxt;
               if (cnt == '0) begin
                  product <= p_nxt;
                  done    <= 1'b1;
                  state   <= ST_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_multiplier_ctrl.sv
// Scoreboard bench: driver pushes expected product and done cycle, monitor pops on done.
module tb_seq_multiplier_ctrl;
   localparam int W = 32;
   localparam int LAT = W;

   typedef struct {
      logic [2*W-1:0] prod;
      int             cyc;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic           busy, done;
   logic [2*W-1:0] product;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   seq_multiplier_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("product", product, e.prod);
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [2*W-1:0] exp);
      exp_t e;
      @(negedge clk);
      start = 1'b1; a = ta; b = tb_;
      @(posedge clk); #1;
      e.prod = exp; e.cyc = cyc + LAT;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 200);
      chk({name, "_timeout"}, 64'(busy), 64'd0);
      chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_product", product, 64'd0);
      rst = 1'b0;

      // 3 x 5, with busy width measured
      begin
         int n = 0;
         op(32'd3, 32'd5, 64'd15);
         n = 1;
         while (n < 100) begin
            @(negedge clk);
            if (!busy) break;
            n++;
         end
         chk("busy_cycles", 64'(n), 64'd33);
         chk("product_hold", product, 64'd15);
      end
      wait_idle("t1");

      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      wait_idle("t2");
      op(32'd0, 32'hDEAD_BEEF, 64'd0);
      wait_idle("t3");
      op(32'h1234_5678, 32'd0, 64'd0);
      wait_idle("t4");
      op(32'hABCD_0001, 32'h0000_0100, 64'h0000_00AB_CD00_0100);
      wait_idle("t5");

      // start pulse mid-CALC is ignored
      op(32'd7, 32'd6, 64'd42);
      repeat (10) @(negedge clk);
      start = 1'b1; a = 32'd2; b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      wait_idle("t6");
      repeat (3) @(negedge clk);
      chk("idle_after_ignored", 64'(busy), 64'd0);
      op(32'd2, 32'd2, 64'd4);
      wait_idle("t7");

      // start held high: back-to-back every W+2 cycles
      begin
         exp_t e;
         int k;
         @(negedge clk);
         start = 1'b1; a = 32'd10; b = 32'd11;
         @(posedge clk); #1;
         k = cyc;
         e.prod = 64'd110; e.cyc = k + LAT;      exp_q.push_back(e);
         e.prod = 64'd110; e.cyc = k + LAT + 34; exp_q.push_back(e);
         repeat (34) @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         wait_idle("t8");
      end

      // reset at iteration 10 aborts without done
      op(32'd9, 32'd9, 64'd81);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_product", product, 64'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("abort_no_done_product", product, 64'd0);
      op(32'd9, 32'd9, 64'd81);
      wait_idle("t9");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
